// File: rtl/banked_mem_pkg.sv
// -----------------------------------------------------------------------------
// banked_mem_pkg
// Shared constants and helpers for the banked multi-port data memory.
//   clog2    : constant ceil(log2) used to size bank/row/pointer fields
//   popcount : number of set bits in a port vector (up to MAX_PORTS ports)
// BANK_BITS / ROW_BITS describe the default 4-bank, 12-bit-address build;
// the top recomputes its own values from its parameters.
// -----------------------------------------------------------------------------
package banked_mem_pkg;

  localparam int MAX_PORTS      = 8;
  localparam int DEF_BANK_COUNT = 4;
  localparam int DEF_ADDR_WIDTH = 12;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int BANK_BITS = clog2(DEF_BANK_COUNT);
  localparam int ROW_BITS  = DEF_ADDR_WIDTH - BANK_BITS;

  function automatic logic [3:0] popcount(input logic [MAX_PORTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/banked_multiport_ram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for one memory bank.
//   clk, reset : system clock, synchronous active-low reset
//   i_req      : per-port requests targeting this bank
//   o_gnt      : one-hot grant (combinational, forced low during reset)
//   o_ptr      : registered round-robin pointer (highest-priority port)
// -----------------------------------------------------------------------------
module rr_arbiter
  import banked_mem_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_gnt;
  logic             w_found;
  int               w_best;
  int               w_best_dist;
  int               w_dist;

  // Winner is the requester with the smallest wrap-around distance from the
  // pointer; written as a distance compare so every index stays static.
  always_comb begin
    w_gnt       = '0;
    w_found     = 1'b0;
    w_best      = 0;
    w_best_dist = N;
    w_dist      = 0;
    for (int j = 0; j < N; j++) begin
      if (j >= int'(r_ptr)) w_dist = j - int'(r_ptr);
      else                  w_dist = j + N - int'(r_ptr);
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = j;
        w_found     = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      w_gnt[j] = w_found && (w_best == j);
    end
    if (!w_found)            w_ptr_nxt = r_ptr;
    else if (w_best == N-1)  w_ptr_nxt = '0;
    else                     w_ptr_nxt = PTR_W'(w_best + 1);
  end

  always_ff @(posedge clk) begin
    if (!reset) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end

  assign o_gnt = reset ? w_gnt : '0;
  assign o_ptr = r_ptr;

endmodule

// File: rtl/banked_multiport_ram.sv
// -----------------------------------------------------------------------------
// banked_multiport_ram
// N-port, B-bank shared data RAM with per-bank round-robin arbitration.
//   clk, reset     : system clock, synchronous active-low reset
//   req/we         : per-port request and write enable
//   addr/wdata     : per-port packed address / write data slices
//   gnt            : per-port grant, combinational in the request cycle
//   rvalid/rdata   : per-port registered read response (1-cycle latency)
//   conflict_count : saturating count of stalled port-cycles
// Bank = low address bits, row = remaining high bits.
// -----------------------------------------------------------------------------
module banked_multiport_ram
  import banked_mem_pkg::*;
#(
  parameter int PORT_COUNT = 4,
  parameter int MEM_WIDTH  = 12,
  parameter int MEM_SIZE   = 4096,
  parameter int BANK_COUNT = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PORT_COUNT-1:0]            req,
  input  logic [PORT_COUNT-1:0]            we,
  input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [PORT_COUNT*MEM_WIDTH-1:0]  wdata,
  output logic [PORT_COUNT-1:0]            gnt,
  output logic [PORT_COUNT-1:0]            rvalid,
  output logic [PORT_COUNT*MEM_WIDTH-1:0]  rdata,
  output logic [CNT_WIDTH-1:0]             conflict_count
);

  localparam int L_BANK_BITS = clog2(BANK_COUNT);
  localparam int L_BANK_W    = (L_BANK_BITS > 0) ? L_BANK_BITS : 1;
  localparam int L_ROW_BITS  = ADDR_WIDTH - L_BANK_BITS;
  localparam int L_ROW_W     = (L_ROW_BITS > 0) ? L_ROW_BITS : 1;
  localparam int DEPTH       = MEM_SIZE / BANK_COUNT;
  localparam int PTR_W       = (PORT_COUNT > 1) ? clog2(PORT_COUNT) : 1;

  logic [L_BANK_W-1:0]   w_port_bank [PORT_COUNT];
  logic [L_ROW_W-1:0]    w_port_row  [PORT_COUNT];
  logic [PORT_COUNT-1:0] w_bank_req  [BANK_COUNT];
  logic [PORT_COUNT-1:0] w_bank_gnt  [BANK_COUNT];
  // Pointers are not needed by the datapath; kept as probe points.
  logic [PTR_W-1:0]      w_unused_ptr [BANK_COUNT];

  logic                  w_bank_act   [BANK_COUNT];
  logic                  w_bank_we    [BANK_COUNT];
  logic [L_ROW_W-1:0]    w_bank_row   [BANK_COUNT];
  logic [MEM_WIDTH-1:0]  w_bank_wdata [BANK_COUNT];
  logic [MEM_WIDTH-1:0]  w_bank_q     [BANK_COUNT];

  logic [PORT_COUNT-1:0] w_gnt;
  logic [PORT_COUNT-1:0] w_stall;
  logic [MAX_PORTS-1:0]  w_stall_ext;
  logic [3:0]            w_inc;
  logic [CNT_WIDTH:0]    w_sum;

  logic [MEM_WIDTH-1:0]           r_mem [BANK_COUNT][DEPTH];
  logic [PORT_COUNT-1:0]          r_rvalid;
  logic [PORT_COUNT*MEM_WIDTH-1:0] r_rdata;
  logic [CNT_WIDTH-1:0]           r_cnt;

  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      w_port_bank[p] = L_BANK_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] % BANK_COUNT);
      w_port_row[p]  = L_ROW_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> L_BANK_BITS);
    end
  end

  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        w_bank_req[b][p] = req[p] && (int'(w_port_bank[p]) == b);
      end
    end
  end

  for (genvar gb = 0; gb < BANK_COUNT; gb++) begin : g_bank
    rr_arbiter #(.N(PORT_COUNT), .PTR_W(PTR_W)) u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (w_bank_req[gb]),
      .o_gnt (w_bank_gnt[gb]),
      .o_ptr (w_unused_ptr[gb])
    );
  end

  // Grants are one-hot per bank, so the winner mux can simply take the
  // granted port's fields.
  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      w_bank_act[b]   = 1'b0;
      w_bank_we[b]    = 1'b0;
      w_bank_row[b]   = '0;
      w_bank_wdata[b] = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (w_bank_gnt[b][p]) begin
          w_bank_act[b]   = 1'b1;
          w_bank_we[b]    = we[p];
          w_bank_row[b]   = w_port_row[p];
          w_bank_wdata[b] = wdata[p*MEM_WIDTH +: MEM_WIDTH];
        end
      end
      w_gnt = w_gnt | w_bank_gnt[b];
      w_bank_q[b] = r_mem[b][w_bank_row[b]];
    end
  end

  // Storage is deliberately not reset; only the write strobe honours reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (reset && w_bank_act[b] && w_bank_we[b]) begin
        r_mem[b][w_bank_row[b]] <= w_bank_wdata[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        r_rvalid[p] <= w_gnt[p] & ~we[p];
        if (w_gnt[p] && !we[p]) begin
          r_rdata[p*MEM_WIDTH +: MEM_WIDTH] <= w_bank_q[w_port_bank[p]];
        end
      end
    end
  end

  always_comb begin
    w_stall     = req & ~w_gnt;
    w_stall_ext = '0;
    w_stall_ext[PORT_COUNT-1:0] = w_stall;
    w_inc       = popcount(w_stall_ext);
    w_sum       = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_inc);
  end

  always_ff @(posedge clk) begin
    if (!reset)              r_cnt <= '0;
    else if (w_sum[CNT_WIDTH]) r_cnt <= '1;
    else                     r_cnt <= w_sum[CNT_WIDTH-1:0];
  end

  assign gnt            = w_gnt;
  assign rvalid         = r_rvalid;
  assign rdata          = r_rdata;
  assign conflict_count = r_cnt;

endmodule
